// File: rtl/div_module.sv
// Iterative signed divider (32-bit dividend / 16-bit divisor), one restoring step per clock.
// Optional macro DIV_REMAINDER_EN adds the data_remainder output and its register.
module div_module #(
  parameter int DW = 32,
  parameter int SW = 16,
  parameter int CW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] data_A,
  input  logic [SW-1:0] data_B,
  input  logic          div_signal,
  output logic [DW-1:0] data_result,
  output logic          exception,
  output logic          input_RDY,
  output logic          result_RDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [SW-1:0] data_remainder
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  localparam logic [DW-1:0] MIN_NEG   = {1'b1, {(DW-1){1'b0}}};

  // Magnitude of a two's complement value; MIN_NEG maps to itself, which is its correct unsigned magnitude.
  function automatic logic [DW-1:0] abs_mag(input logic signed [DW-1:0] v);
    logic [DW-1:0] u;
    u = v;
    if (v[DW-1]) u = ~u + DW'(1);
    return u;
  endfunction

  function automatic logic signed [DW-1:0] apply_sign(input logic [DW-1:0] mag, input logic neg);
    logic [DW-1:0] r;
    r = mag;
    if (neg) r = ~mag + DW'(1);
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DW-1:0]        result_q, result_d;
  logic                 exc_q, exc_d;
  logic [DW-1:0]        rem_q, rem_d;
  logic [DW-1:0]        quo_q, quo_d;
  logic [DW-1:0]        dvs_q, dvs_d;
  logic                 qsign_q, qsign_d;
`ifdef DIV_REMAINDER_EN
  logic                 asign_q, asign_d;
  logic [SW-1:0]        rem_out_q, rem_out_d;
`endif

  logic signed [DW-1:0] b_sext;
  logic [DW:0]          rem_sh;
  logic [DW-1:0]        rem_diff;
  logic [DW-1:0]        rem_nxt;
  logic [DW-1:0]        quo_nxt;
  logic                 step_ge;

  assign b_sext = {{(DW-SW){data_B[SW-1]}}, data_B};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qsign_d  = qsign_q;
`ifdef DIV_REMAINDER_EN
    asign_d   = asign_q;
    rem_out_d = rem_out_q;
`endif

    // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
    rem_sh   = {rem_q, quo_q[DW-1]};
    step_ge  = (rem_sh >= {1'b0, dvs_q});
    rem_diff = rem_sh[DW-1:0] - dvs_q;
    rem_nxt  = step_ge ? rem_diff : rem_sh[DW-1:0];
    quo_nxt  = {quo_q[DW-2:0], step_ge};

    case (state_q)
      S_IDLE: begin
        if (div_signal) begin
          if (data_B == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = S_DONE;
`ifdef DIV_REMAINDER_EN
            rem_out_d = '0;
`endif
          end else if (data_A == MIN_NEG && data_B == '1) begin
            result_d = MIN_NEG;
            exc_d    = 1'b1;
            state_d  = S_DONE;
`ifdef DIV_REMAINDER_EN
            rem_out_d = '0;
`endif
          end else begin
            rem_d   = '0;
            quo_d   = abs_mag(data_A);
            dvs_d   = abs_mag(b_sext);
            qsign_d = data_A[DW-1] ^ data_B[SW-1];
            count_d = '0;
            state_d = S_RUN;
`ifdef DIV_REMAINDER_EN
            asign_d = data_A[DW-1];
`endif
          end
        end
      end
      S_RUN: begin
        rem_d   = rem_nxt;
        quo_d   = quo_nxt;
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          result_d = apply_sign(quo_nxt, qsign_q);
          exc_d    = 1'b0;
          state_d  = S_DONE;
`ifdef DIV_REMAINDER_EN
          rem_out_d = SW'(apply_sign(rem_nxt, asign_q));
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible outputs: reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_out_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef DIV_REMAINDER_EN
      rem_out_q <= rem_out_d;
`endif
    end
  end

  // Working datapath: always reloaded at start, so it carries no reset.
  always_ff @(posedge clock) begin
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dvs_q   <= dvs_d;
    qsign_q <= qsign_d;
`ifdef DIV_REMAINDER_EN
    asign_q <= asign_d;
`endif
  end

  assign data_result = result_q;
  assign exception   = exc_q;
  assign input_RDY   = (state_q == S_IDLE);
  assign result_RDY  = (state_q == S_DONE);
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_div_module.sv
// Directed bench for div_module: vector table of divisions plus strobe-hold and reset-abort sequences.
module tb_div_module;

  logic        clock;
  logic        reset;
  logic [31:0] data_A;
  logic [15:0] data_B;
  logic        div_signal;
  logic [31:0] data_result;
  logic        exception;
  logic        input_RDY;
  logic        result_RDY;
`ifdef DIV_REMAINDER_EN
  logic [15:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  div_module dut (
    .clock       (clock),
    .reset       (reset),
    .data_A      (data_A),
    .data_B      (data_B),
    .div_signal  (div_signal),
    .data_result (data_result),
    .exception   (exception),
    .input_RDY   (input_RDY),
    .result_RDY  (result_RDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic        exc;
    int          lat;
    logic [15:0] rem;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start one operation, scramble operands after the start edge, wait for result_RDY.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, output int lat,
                       output logic [31:0] q, output logic exc, output logic [15:0] rem);
    @(negedge clock);
    data_A = a;
    data_B = b;
    div_signal = 1'b1;
    @(posedge clock);
    lat = 1;
    #1;
    div_signal = 1'b0;
    data_A = $urandom;
    data_B = 16'($urandom);
    @(negedge clock);
    while (!result_RDY && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    q = data_result;
    exc = exception;
`ifdef DIV_REMAINDER_EN
    rem = data_remainder;
`else
    rem = 16'h0;
`endif
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    logic        exc;
    logic [15:0] rem;
    int          pulses;

    vecs[0]  = '{32'd100,       16'd7,      32'd14,        1'b0, 33, 16'd2};
    vecs[1]  = '{32'hFFFF_FF9C, 16'd7,      32'hFFFF_FFF2, 1'b0, 33, 16'hFFFE};
    vecs[2]  = '{32'd7,         16'hFFFF,   32'hFFFF_FFF9, 1'b0, 33, 16'd0};
    vecs[3]  = '{32'hFFFF_8000, 16'h8000,   32'd1,         1'b0, 33, 16'd0};
    vecs[4]  = '{32'd5,         16'd0,      32'd0,         1'b1, 1,  16'd0};
    vecs[5]  = '{32'd100,       16'd7,      32'd14,        1'b0, 33, 16'd2};
    vecs[6]  = '{32'h8000_0000, 16'hFFFF,   32'h8000_0000, 1'b1, 1,  16'd0};
    vecs[7]  = '{32'h8000_0000, 16'h0001,   32'h8000_0000, 1'b0, 33, 16'd0};
    vecs[8]  = '{32'h7FFF_FFFF, 16'h7FFF,   32'h0001_0002, 1'b0, 33, 16'd1};
    vecs[9]  = '{32'hFFFF_FFF9, 16'd2,      32'hFFFF_FFFD, 1'b0, 33, 16'hFFFF};
    vecs[10] = '{32'h8000_0000, 16'h8000,   32'h0001_0000, 1'b0, 33, 16'd0};
    vecs[11] = '{32'd0,         16'd5,      32'd0,         1'b0, 33, 16'd0};
    vecs[12] = '{32'd1000,      16'hFFFD,   32'hFFFF_FEB3, 1'b0, 33, 16'd1};

    reset = 1'b1;
    div_signal = 1'b0;
    data_A = 32'h0;
    data_B = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", 32'(exception), 32'h0);
    chk("reset_inrdy", 32'(input_RDY), 32'h1);
    chk("reset_resrdy", 32'(result_RDY), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, q, exc, rem);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quot", i), q, vecs[i].q);
      chk($sformatf("v%0d_exc", i), 32'(exc), 32'(vecs[i].exc));
      chk($sformatf("v%0d_inrdy_done", i), 32'(input_RDY), 32'h0);
`ifdef DIV_REMAINDER_EN
      chk($sformatf("v%0d_rem", i), 32'(rem), 32'(vecs[i].rem));
`endif
    end

    // Held result survives idle cycles.
    repeat (5) @(negedge clock);
    chk("hold_result", data_result, 32'hFFFF_FEB3);
    chk("hold_resrdy", 32'(result_RDY), 32'h0);

    // Strobe held high over three operations; operand changes mid-RUN.
    @(negedge clock);
    data_A = 32'd100;
    data_B = 16'd7;
    div_signal = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 104; t++) begin
      @(posedge clock);
      @(negedge clock);
      if (t % 34 == 10) data_A = 32'd12345;
      if (t % 34 == 20) data_A = 32'd100;
      if (t == 101) div_signal = 1'b0;
      if (result_RDY) begin
        pulses++;
        chk($sformatf("hold_pulse_t%0d_phase", t), 32'(t % 34), 32'd33);
        chk($sformatf("hold_pulse_t%0d_quot", t), data_result, 32'd14);
      end
    end
    chk("hold_pulse_count", 32'(pulses), 32'd3);

    // Reset ten cycles into RUN aborts the operation.
    repeat (3) @(negedge clock);
    data_A = 32'd100;
    data_B = 16'd7;
    div_signal = 1'b1;
    @(posedge clock);
    #1;
    div_signal = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("abort_busy", 32'(input_RDY), 32'h0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", data_result, 32'h0);
    chk("abort_exc", 32'(exception), 32'h0);
    chk("abort_inrdy", 32'(input_RDY), 32'h1);
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (result_RDY) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
